// File: rtl/rob_tag_allocator_pkg.sv
// ---------------------------------------------------------------------------
// rob_tag_allocator_pkg
// Shared definitions for the ROB tag allocator slice: default ROB capacity
// and tag width, the reserved null tag, boolean constants and the allocator
// FSM state type.
// ---------------------------------------------------------------------------
package rob_tag_allocator_pkg;

  // Default ROB geometry: 15 live tags fit in a 4-bit tag with 0 reserved.
  localparam int ROB_TAG_W     = 4;
  localparam int ROB_CAPACITY  = 15;
  localparam int ROB_TAG_RANGE = ROB_CAPACITY;

  // Tag 0 means "no producer" in the register file and is never handed out.
  localparam int NULL_TAG  = 0;
  localparam int FIRST_TAG = 1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // RUN: normal allocate/commit; RECOVER: allocation blocked after a flush.
  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/rob_tag_allocator_tag_ring_inc.sv
// ---------------------------------------------------------------------------
// tag_ring_inc
// Combinational wrap-around increment over the live tag range 1..DEPTH.
// Tag 0 is never produced.
// Ports:
//   tag       in   TAG_WIDTH  current tag (1..DEPTH)
//   tag_next  out  TAG_WIDTH  successor tag, DEPTH wraps to 1
// ---------------------------------------------------------------------------
module tag_ring_inc
  import rob_tag_allocator_pkg::*;
#(
  parameter int TAG_WIDTH = ROB_TAG_W,
  parameter int DEPTH     = ROB_CAPACITY
) (
  input  logic [TAG_WIDTH-1:0] tag,
  output logic [TAG_WIDTH-1:0] tag_next
);

  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(DEPTH);
  localparam logic [TAG_WIDTH-1:0] WRAP_TAG = TAG_WIDTH'(FIRST_TAG);

  assign tag_next = (tag == LAST_TAG) ? WRAP_TAG : tag + TAG_WIDTH'(1);

endmodule

// File: rtl/rob_tag_allocator.sv
// ---------------------------------------------------------------------------
// rob_tag_allocator
// Hands ROB tags (1..DEPTH) to the decoder, retires them in program order on
// ROB commit and resets the ring on a mispredict rollback, blocking
// allocation for RECOVER_CYCLES afterwards.
// Ports:
//   clk                   in   1            clock
//   rst_n                 in   1            async active-low reset
//   dec_alloc_req_in      in   1            decoder wants a tag this cycle
//   alloc_ready_out       out  1            allocation accepted this cycle
//   next_tag_out          out  TAG_WIDTH    tag granted on handshake (tail)
//   rob_commit_signal_in  in   1            ROB retires its head entry
//   rob_commit_tag_in     in   TAG_WIDTH    tag being retired
//   rob_rollback_in       in   1            flush: every tag becomes free
//   head_tag_out          out  TAG_WIDTH    oldest live tag, 0 when empty
//   count_out             out  TAG_WIDTH+1  number of live tags
//   full_out              out  1            count == DEPTH
//   empty_out             out  1            count == 0
//   order_err_out         out  1            sticky bad-commit flag
// ---------------------------------------------------------------------------
module rob_tag_allocator
  import rob_tag_allocator_pkg::*;
#(
  parameter int TAG_WIDTH      = ROB_TAG_W,
  parameter int DEPTH          = ROB_CAPACITY,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_alloc_req_in,
  output logic                 alloc_ready_out,
  output logic [TAG_WIDTH-1:0] next_tag_out,
  input  logic                 rob_commit_signal_in,
  input  logic [TAG_WIDTH-1:0] rob_commit_tag_in,
  input  logic                 rob_rollback_in,
  output logic [TAG_WIDTH-1:0] head_tag_out,
  output logic [TAG_WIDTH:0]   count_out,
  output logic                 full_out,
  output logic                 empty_out,
  output logic                 order_err_out
);

  localparam int RC_W = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

  localparam logic [TAG_WIDTH-1:0] TAG_ONE    = TAG_WIDTH'(FIRST_TAG);
  localparam logic [TAG_WIDTH-1:0] TAG_NULL   = TAG_WIDTH'(NULL_TAG);
  localparam logic [TAG_WIDTH:0]   FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);
  localparam logic [TAG_WIDTH:0]   CNT_ONE    = (TAG_WIDTH + 1)'(1);
  localparam logic [RC_W-1:0]      RC_LOAD    = RC_W'(RECOVER_CYCLES);
  localparam logic [RC_W-1:0]      RC_ONE     = RC_W'(1);

  alloc_state_t         state_q, state_d;
  logic [TAG_WIDTH-1:0] head_q, head_d;
  logic [TAG_WIDTH-1:0] tail_q, tail_d;
  logic [TAG_WIDTH:0]   count_q, count_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic                 err_q, err_d;

  logic [TAG_WIDTH-1:0] head_inc;
  logic [TAG_WIDTH-1:0] tail_inc;
  logic                 is_full;
  logic                 is_empty;
  logic                 grant;
  logic                 commit_ok;
  logic                 commit_bad;

  tag_ring_inc #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH)
  ) u_head_inc (
    .tag      (head_q),
    .tag_next (head_inc)
  );

  tag_ring_inc #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH)
  ) u_tail_inc (
    .tag      (tail_q),
    .tag_next (tail_inc)
  );

  assign is_full  = (count_q == FULL_COUNT);
  assign is_empty = (count_q == '0);

  // Ready depends only on registered state, so a commit that frees a slot
  // while full only opens allocation on the following cycle.
  assign alloc_ready_out = (state_q == RUN) && !is_full;
  assign grant           = dec_alloc_req_in && alloc_ready_out;

  // Commits are only judged in RUN; an empty ring makes any commit an error,
  // even when a grant lands in the same cycle.
  assign commit_ok  = (state_q == RUN) && rob_commit_signal_in && !is_empty &&
                      (rob_commit_tag_in == head_q);
  assign commit_bad = (state_q == RUN) && rob_commit_signal_in && !commit_ok;

  // State register for the FSM and the tag ring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      head_q  <= TAG_ONE;
      tail_q  <= TAG_ONE;
      count_q <= '0;
      rc_q    <= '0;
      err_q   <= FALSE;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rc_q    <= rc_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: rollback beats everything, RECOVER counts down and
  // ignores commits, RUN handles grant and commit independently.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rc_d    = rc_q;
    err_d   = err_q;

    if (rob_rollback_in) begin
      head_d  = TAG_ONE;
      tail_d  = TAG_ONE;
      count_d = '0;
      state_d = RECOVER;
      rc_d    = RC_LOAD;
    end else begin
      unique case (state_q)
        RUN: begin
          if (grant) begin
            tail_d = tail_inc;
          end
          if (commit_ok) begin
            head_d = head_inc;
          end
          if (commit_bad) begin
            err_d = TRUE;
          end
          unique case ({grant, commit_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
          endcase
        end
        RECOVER: begin
          if (rc_q <= RC_ONE) begin
            state_d = RUN;
          end else begin
            rc_d = rc_q - RC_ONE;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign next_tag_out  = tail_q;
  assign head_tag_out  = is_empty ? TAG_NULL : head_q;
  assign count_out     = count_q;
  assign full_out      = is_full;
  assign empty_out     = is_empty;
  assign order_err_out = err_q;

endmodule

// File: tb/tb_rob_tag_allocator.sv
// ---------------------------------------------------------------------------
// tb_rob_tag_allocator
// Self-checking bench for rob_tag_allocator: a vector table replayed from
// reset, hand-written corner sequences, and randomized traffic compared with
// a queue-based reference model of the live tag list.
// ---------------------------------------------------------------------------
module tb_rob_tag_allocator;

  localparam int TW    = 4;
  localparam int DEPTH = 15;
  localparam int RCYC  = 1;

  logic          clk;
  logic          rst_n;
  logic          dec_alloc_req_in;
  logic          alloc_ready_out;
  logic [TW-1:0] next_tag_out;
  logic          rob_commit_signal_in;
  logic [TW-1:0] rob_commit_tag_in;
  logic          rob_rollback_in;
  logic [TW-1:0] head_tag_out;
  logic [TW:0]   count_out;
  logic          full_out;
  logic          empty_out;
  logic          order_err_out;

  rob_tag_allocator #(
    .TAG_WIDTH      (TW),
    .DEPTH          (DEPTH),
    .RECOVER_CYCLES (RCYC)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dec_alloc_req_in     (dec_alloc_req_in),
    .alloc_ready_out      (alloc_ready_out),
    .next_tag_out         (next_tag_out),
    .rob_commit_signal_in (rob_commit_signal_in),
    .rob_commit_tag_in    (rob_commit_tag_in),
    .rob_rollback_in      (rob_rollback_in),
    .head_tag_out         (head_tag_out),
    .count_out            (count_out),
    .full_out             (full_out),
    .empty_out            (empty_out),
    .order_err_out        (order_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ready;
    int next;
    int head;
    int count;
    int full;
    int empty;
    int err;
  } exp_t;

  typedef struct {
    int   req;
    int   commit;
    int   ctag;
    int   rb;
    exp_t e;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the live tags in program order plus the next tag to issue.
  int live[$];
  int mNext;
  int mErr;
  int mRecLeft;

  task automatic compareField(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    compareField({name, ".ready"}, int'(alloc_ready_out), e.ready);
    compareField({name, ".next"},  int'(next_tag_out),    e.next);
    compareField({name, ".head"},  int'(head_tag_out),    e.head);
    compareField({name, ".count"}, int'(count_out),       e.count);
    compareField({name, ".full"},  int'(full_out),        e.full);
    compareField({name, ".empty"}, int'(empty_out),       e.empty);
    compareField({name, ".err"},   int'(order_err_out),   e.err);
  endtask

  task automatic driveInputs(input int req, input int commit, input int ctag, input int rb);
    dec_alloc_req_in     = (req != 0);
    rob_commit_signal_in = (commit != 0);
    rob_commit_tag_in    = TW'(ctag);
    rob_rollback_in      = (rb != 0);
  endtask

  // Drive one cycle of inputs, cross the edge, and land 1 time unit after it.
  task automatic applyStimulus(input int req, input int commit, input int ctag, input int rb);
    driveInputs(req, commit, ctag, rb);
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    live.delete();
    mNext    = 1;
    mErr     = 0;
    mRecLeft = 0;
  endtask

  task automatic doReset();
    driveInputs(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  function automatic exp_t modelExpect();
    exp_t e;
    e.ready = (mRecLeft == 0 && live.size() < DEPTH) ? 1 : 0;
    e.next  = mNext;
    e.head  = (live.size() > 0) ? live[0] : 0;
    e.count = live.size();
    e.full  = (live.size() == DEPTH) ? 1 : 0;
    e.empty = (live.size() == 0) ? 1 : 0;
    e.err   = mErr;
    return e;
  endfunction

  task automatic modelStep(input int req, input int commit, input int ctag, input int rb);
    bit ready;
    ready = (mRecLeft == 0 && live.size() < DEPTH);
    if (rb != 0) begin
      live.delete();
      mNext    = 1;
      mRecLeft = RCYC;
    end else if (mRecLeft > 0) begin
      mRecLeft--;
    end else begin
      if (commit != 0) begin
        if (live.size() > 0 && live[0] == ctag) void'(live.pop_front());
        else mErr = 1;
      end
      if (req != 0 && ready) begin
        live.push_back(mNext);
        mNext = (mNext % DEPTH) + 1;
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;
    int   req, commit, ctag, rb;

    rst_n = 1'b0;
    driveInputs(0, 0, 0, 0);

    // Vector table replayed from reset; expectations are after each edge.
    vecs[0]  = '{1, 0, 0, 0, '{1, 2, 1, 1, 0, 0, 0}};
    vecs[1]  = '{1, 0, 0, 0, '{1, 3, 1, 2, 0, 0, 0}};
    vecs[2]  = '{1, 0, 0, 0, '{1, 4, 1, 3, 0, 0, 0}};
    vecs[3]  = '{1, 1, 1, 0, '{1, 5, 2, 3, 0, 0, 0}};
    vecs[4]  = '{0, 1, 2, 0, '{1, 5, 3, 2, 0, 0, 0}};
    vecs[5]  = '{0, 1, 3, 0, '{1, 5, 4, 1, 0, 0, 0}};
    vecs[6]  = '{0, 1, 4, 0, '{1, 5, 0, 0, 0, 1, 0}};
    vecs[7]  = '{1, 1, 5, 0, '{1, 6, 5, 1, 0, 0, 1}};
    vecs[8]  = '{0, 1, 7, 0, '{1, 6, 5, 1, 0, 0, 1}};
    vecs[9]  = '{1, 0, 0, 1, '{0, 1, 0, 0, 0, 1, 1}};
    vecs[10] = '{1, 0, 0, 0, '{1, 1, 0, 0, 0, 1, 1}};
    vecs[11] = '{1, 0, 0, 0, '{1, 2, 1, 1, 0, 0, 1}};

    doReset();
    checkOutput("reset", '{1, 1, 0, 0, 0, 1, 0});
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req, vecs[i].commit, vecs[i].ctag, vecs[i].rb);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    // Fill all 15 tags, commit while full with req held, then wrap to tag 1.
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("full", '{0, 1, 1, 15, 1, 0, 0});
    driveInputs(1, 1, 1, 0);
    compareField("full_commit.ready_pre", int'(alloc_ready_out), 0);
    @(posedge clk);
    #1;
    checkOutput("full_commit", '{1, 1, 2, 14, 0, 0, 0});
    applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_grant", '{0, 2, 2, 15, 1, 0, 0});

    // Five live tags, out-of-order commit of tag 3: error is sticky.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 3, 0);
    checkOutput("ooo_commit", '{1, 6, 1, 5, 0, 0, 1});
    applyStimulus(0, 0, 0, 0);
    checkOutput("ooo_sticky", '{1, 6, 1, 5, 0, 0, 1});

    // Six live tags, rollback with req held, then recovery.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("rollback", '{0, 1, 0, 0, 0, 1, 0});
    applyStimulus(0, 0, 0, 0);
    checkOutput("recovered", '{1, 1, 0, 0, 0, 1, 0});

    // Async reset mid-cycle with 8 live tags, error set and RECOVER active.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 9, 0);
    applyStimulus(1, 0, 0, 1);
    driveInputs(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", '{1, 1, 0, 0, 0, 1, 0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compareField("reset_release.ready", int'(alloc_ready_out), 1);

    // Randomized traffic against the live-tag queue model.
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) doReset();
      req    = ($urandom_range(0, 9) < 7) ? 1 : 0;
      commit = ($urandom_range(0, 9) < 4) ? 1 : 0;
      if (live.size() > 0 && $urandom_range(0, 9) < 8) ctag = live[0];
      else ctag = $urandom_range(0, 15);
      rb = ($urandom_range(0, 99) < 3) ? 1 : 0;
      driveInputs(req, commit, ctag, rb);
      e = modelExpect();
      checkOutput($sformatf("rand%0d", cyc), e);
      @(posedge clk);
      #1;
      modelStep(req, commit, ctag, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
